// File: rtl/blockade_pkg.sv
// Shared types and constants for the Blockade loader: ioctl stream indices,
// ROM region bounds, game modes and loader FSM states.
package blockade_pkg;

   localparam logic [13:0] PROG_END  = 14'h1000;
   localparam logic [13:0] GFX_END   = 14'h1800;
   localparam logic [14:0] MIN_BYTES = 15'd2048;
   localparam logic [4:0]  HOLD_CYC  = 5'd16;

   localparam logic [7:0] IDX_ROM  = 8'd0;
   localparam logic [7:0] IDX_MODE = 8'd1;
   localparam logic [7:0] IDX_DIP  = 8'd254;

   typedef enum logic [1:0] {
      GAME_BLOCKADE = 2'd0,
      GAME_COMOTION = 2'd1,
      GAME_HUSTLE   = 2'd2,
      GAME_BLASTO   = 2'd3
   } game_mode_t;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_LOAD  = 3'd1,
      ST_HOLD  = 3'd2,
      ST_RUN   = 3'd3,
      ST_ERROR = 3'd4
   } loader_state_t;

   typedef struct packed {
      loader_state_t state;
      logic [14:0]   byte_cnt;
      logic          nz_seen;
      logic [4:0]    hold_cnt;
   } loader_dbg_t;

endpackage

// File: rtl/blockade_loader_ctrl.sv
// Routes the HPS ioctl ROM stream into the Blockade program/graphics ROMs,
// latches game mode and DIP bytes, and owns the core reset.
module blockade_loader_ctrl
   import blockade_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic        ioctl_download,
   input  logic        ioctl_wr,
   input  logic [7:0]  ioctl_index,
   input  logic [24:0] ioctl_addr,
   input  logic [7:0]  ioctl_dout,
   input  logic        rst_req,
   output logic [13:0] rom_addr,
   output logic [7:0]  rom_data,
   output logic        rom_wr_prog,
   output logic        rom_wr_gfx,
   output game_mode_t  game_mode,
   output logic [7:0]  sw0,
   output logic [7:0]  sw1,
   output logic        core_reset,
   output logic        load_busy,
   output logic        load_error,
   output loader_dbg_t dbg
);

   // Handshake: ioctl_wr is a one-cycle strobe qualifying ioctl_index/addr/dout;
   // there is no back-pressure, every strobe is consumed in the cycle it appears.

   loader_state_t state;
   logic [14:0]   byte_cnt;
   logic          nz_seen;
   logic [4:0]    hold_cnt;

   logic          rom_download, rom_download_q;
   logic          dl_rise, dl_fall;
   logic          in_range, count_byte;
   logic [14:0]   cnt_base;
   logic          nz_base;

   always_comb begin
      rom_download = ioctl_download && (ioctl_index == IDX_ROM);
      dl_rise      = rom_download && !rom_download_q;
      dl_fall      = !rom_download && rom_download_q;
      in_range     = (ioctl_addr[24:14] == 11'd0) && (ioctl_addr[13:0] < GFX_END);
      // A byte arriving with the rising edge of the download belongs to the new image.
      count_byte   = ioctl_wr && rom_download && in_range && ((state == ST_LOAD) || dl_rise);
      cnt_base     = dl_rise ? 15'd0 : byte_cnt;
      nz_base      = dl_rise ? 1'b0 : nz_seen;
   end

   always_comb begin
      dbg          = '0;
      dbg.state    = state;
      dbg.byte_cnt = byte_cnt;
      dbg.nz_seen  = nz_seen;
      dbg.hold_cnt = hold_cnt;
   end

   // Edge history is kept across reset so a download still active after reset is not re-entered.
   always_ff @(posedge clk) begin
      rom_download_q <= rom_download;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= ST_IDLE;
         byte_cnt    <= 15'd0;
         nz_seen     <= 1'b0;
         hold_cnt    <= HOLD_CYC;
         rom_addr    <= 14'd0;
         rom_data    <= 8'd0;
         rom_wr_prog <= 1'b0;
         rom_wr_gfx  <= 1'b0;
         game_mode   <= GAME_BLOCKADE;
         sw0         <= 8'd0;
         sw1         <= 8'd0;
         core_reset  <= 1'b1;
         load_busy   <= 1'b0;
         load_error  <= 1'b0;
      end else begin
         rom_wr_prog <= 1'b0;
         rom_wr_gfx  <= 1'b0;
         if (ioctl_wr && rom_download && in_range) begin
            rom_data <= ioctl_dout;
            if (ioctl_addr[13:0] < PROG_END) begin
               rom_wr_prog <= 1'b1;
               rom_addr    <= ioctl_addr[13:0];
            end else begin
               rom_wr_gfx  <= 1'b1;
               rom_addr    <= ioctl_addr[13:0] - PROG_END;
            end
         end

         if (ioctl_wr && (ioctl_index == IDX_MODE))
            game_mode <= game_mode_t'(ioctl_dout[1:0]);
         if (ioctl_wr && (ioctl_index == IDX_DIP) && (ioctl_addr[24:1] == 24'd0)) begin
            if (ioctl_addr[0]) sw1 <= ioctl_dout;
            else               sw0 <= ioctl_dout;
         end

         if (count_byte) begin
            byte_cnt <= (cnt_base == 15'h7FFF) ? cnt_base : cnt_base + 15'd1;
            nz_seen  <= nz_base | (ioctl_dout != 8'd0);
         end else if (dl_rise) begin
            byte_cnt <= 15'd0;
            nz_seen  <= 1'b0;
         end

         if (dl_rise) begin
            state      <= ST_LOAD;
            load_busy  <= 1'b1;
            load_error <= 1'b0;
            core_reset <= 1'b1;
         end else begin
            case (state)
               ST_LOAD: begin
                  if (dl_fall) begin
                     load_busy <= 1'b0;
                     if ((byte_cnt >= MIN_BYTES) && nz_seen) begin
                        state    <= ST_HOLD;
                        hold_cnt <= HOLD_CYC;
                     end else begin
                        state      <= ST_ERROR;
                        load_error <= 1'b1;
                     end
                  end
               end
               ST_HOLD: begin
                  if (rst_req) begin
                     hold_cnt <= HOLD_CYC;
                  end else if (hold_cnt == 5'd0) begin
                     state      <= ST_RUN;
                     core_reset <= 1'b0;
                  end else begin
                     hold_cnt <= hold_cnt - 5'd1;
                  end
               end
               ST_RUN: begin
                  if (rst_req) begin
                     state      <= ST_HOLD;
                     hold_cnt   <= HOLD_CYC;
                     core_reset <= 1'b1;
                  end
               end
               default: ;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_blockade_loader_ctrl.sv
// Self-checking bench for blockade_loader_ctrl: ROM writes are checked through
// an expected queue, control outputs through direct checks.
module tb_blockade_loader_ctrl;
   import blockade_pkg::*;

   logic        clk = 1'b0;
   logic        reset;
   logic        ioctl_download;
   logic        ioctl_wr;
   logic [7:0]  ioctl_index;
   logic [24:0] ioctl_addr;
   logic [7:0]  ioctl_dout;
   logic        rst_req;
   logic [13:0] rom_addr;
   logic [7:0]  rom_data;
   logic        rom_wr_prog;
   logic        rom_wr_gfx;
   game_mode_t  game_mode;
   logic [7:0]  sw0, sw1;
   logic        core_reset;
   logic        load_busy;
   logic        load_error;
   loader_dbg_t dbg;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   int n_prog = 0;
   int n_gfx  = 0;

   logic [22:0] exp_q[$];
   int          exp_cyc_q[$];

   blockade_loader_ctrl dut (
      .clk(clk), .reset(reset), .ioctl_download(ioctl_download), .ioctl_wr(ioctl_wr),
      .ioctl_index(ioctl_index), .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout),
      .rst_req(rst_req), .rom_addr(rom_addr), .rom_data(rom_data),
      .rom_wr_prog(rom_wr_prog), .rom_wr_gfx(rom_wr_gfx), .game_mode(game_mode),
      .sw0(sw0), .sw1(sw1), .core_reset(core_reset), .load_busy(load_busy),
      .load_error(load_error), .dbg(dbg)
   );

   // clock / reset
   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   // scoreboard: every routed ROM byte must appear exactly one cycle after its ioctl_wr
   always @(negedge clk) begin
      if (!reset) begin
         if (rom_wr_prog || rom_wr_gfx) begin
            if (rom_wr_prog) n_prog++;
            if (rom_wr_gfx)  n_gfx++;
            if (exp_q.size() == 0) begin
               check_eq("spurious_rom_wr", 32'd1, 32'd0);
            end else begin
               check_eq("rom_entry", 32'({rom_wr_gfx, rom_addr, rom_data}), 32'(exp_q.pop_front()));
               check_eq("rom_latency", 32'(cyc), 32'(exp_cyc_q.pop_front() + 1));
               check_eq("rom_one_hot", 32'(rom_wr_prog & rom_wr_gfx), 32'd0);
            end
         end else if (exp_q.size() != 0 && exp_cyc_q[0] + 1 <= cyc) begin
            check_eq("missing_rom_wr", 32'(exp_q.pop_front()), 32'h7FFFFF);
            void'(exp_cyc_q.pop_front());
         end
      end
   end

   // driver tasks
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wr_byte(input logic [7:0] idx, input logic [24:0] addr, input logic [7:0] data);
      logic [13:0] ra;
      ioctl_index = idx;
      ioctl_addr  = addr;
      ioctl_dout  = data;
      ioctl_wr    = 1'b1;
      if (ioctl_download && idx == 8'd0 && addr < 25'h1800) begin
         ra = (addr >= 25'h1000) ? 14'(addr - 25'h1000) : addr[13:0];
         exp_q.push_back({addr >= 25'h1000, ra, data});
         exp_cyc_q.push_back(cyc);
      end
      tick();
      ioctl_wr = 1'b0;
   endtask

   // mode 0: all 0xA5, 1: all zero, 2: random non-zero
   task automatic load_rom(input int n, input int mode);
      logic [7:0] d;
      ioctl_index    = 8'd0;
      ioctl_download = 1'b1;
      for (int i = 0; i < n; i++) begin
         d = (mode == 0) ? 8'hA5 : (mode == 1) ? 8'h00 : 8'($urandom_range(1, 255));
         wr_byte(8'd0, 25'(i), d);
      end
   endtask

   task automatic end_dl();
      ioctl_download = 1'b0;
      tick();
   endtask

   // cycles until core_reset is seen low, bounded
   task automatic measure_high(output int n);
      n = 0;
      while (core_reset && n < 100) begin
         tick();
         n++;
      end
   endtask

   int n;
   int p0;

   initial begin
      reset = 1'b1; ioctl_download = 1'b0; ioctl_wr = 1'b0; ioctl_index = 8'd0;
      ioctl_addr = '0; ioctl_dout = 8'd0; rst_req = 1'b0;
      tick(); tick();
      check_eq("rst_core_reset", 32'(core_reset), 32'd1);
      check_eq("rst_load_busy", 32'(load_busy), 32'd0);
      check_eq("rst_load_error", 32'(load_error), 32'd0);
      check_eq("rst_outputs", 32'({rom_wr_prog, rom_wr_gfx, game_mode, sw0, sw1}), 32'd0);
      check_eq("rst_state", 32'(dbg.state), 32'(ST_IDLE));
      check_eq("rst_hold_cnt", 32'(dbg.hold_cnt), 32'd16);
      check_eq("rst_byte_cnt", 32'(dbg.byte_cnt), 32'd0);
      reset = 1'b0;
      tick();

      // valid 2048-byte image; hold lasts the entry cycle plus HOLD_CYC countdown cycles
      p0 = n_prog;
      load_rom(2048, 0);
      check_eq("t1_load_busy", 32'(load_busy), 32'd1);
      check_eq("t1_cnt", 32'(dbg.byte_cnt), 32'd2048);
      end_dl();
      check_eq("t1_busy_off", 32'(load_busy), 32'd0);
      check_eq("t1_hold_state", 32'(dbg.state), 32'(ST_HOLD));
      check_eq("t1_core_reset_hold", 32'(core_reset), 32'd1);
      measure_high(n);
      check_eq("t1_hold_len", 32'(n), 32'(HOLD_CYC) + 32'd1);
      check_eq("t1_run", 32'(dbg.state), 32'(ST_RUN));
      check_eq("t1_prog_count", 32'(n_prog - p0), 32'd2048);

      // region boundaries; out-of-range bytes are neither written nor counted
      ioctl_index = 8'd0; ioctl_download = 1'b1;
      wr_byte(8'd0, 25'h0000FFF, 8'h3C);
      wr_byte(8'd0, 25'h0001000, 8'h11);
      wr_byte(8'd0, 25'h00017FF, 8'h22);
      wr_byte(8'd0, 25'h0001800, 8'h33);
      wr_byte(8'd0, 25'h0004000, 8'h44);
      wr_byte(8'd0, 25'h1000000, 8'h55);
      tick();
      check_eq("t2_cnt", 32'(dbg.byte_cnt), 32'd3);
      check_eq("t2_gfx_count", 32'(n_gfx), 32'd2);
      end_dl();
      check_eq("t2_short_error", 32'(load_error), 32'd1);

      // all-zero image and one-byte-short image are rejected
      load_rom(4096, 1);
      end_dl();
      check_eq("t3_zero_state", 32'(dbg.state), 32'(ST_ERROR));
      check_eq("t3_zero_error", 32'(load_error), 32'd1);
      check_eq("t3_zero_cnt", 32'(dbg.byte_cnt), 32'd4096);
      rst_req = 1'b1; tick(); rst_req = 1'b0; tick();
      check_eq("t3_err_rst_req", 32'({core_reset, load_error}), 32'b11);
      load_rom(2047, 2);
      end_dl();
      check_eq("t3_2047_error", 32'(dbg.state), 32'(ST_ERROR));
      ioctl_index = 8'd0; ioctl_download = 1'b1;
      wr_byte(8'd0, 25'd0, 8'h5A);
      check_eq("t3_err_clear", 32'(load_error), 32'd0);
      check_eq("t3_first_counted", 32'(dbg.byte_cnt), 32'd1);
      for (int i = 1; i < 2048; i++) wr_byte(8'd0, 25'(i), 8'($urandom_range(1, 255)));
      end_dl();
      measure_high(n);
      check_eq("t3_reload_hold", 32'(n), 32'(HOLD_CYC) + 32'd1);
      check_eq("t3_run", 32'(dbg.state), 32'(ST_RUN));

      // user reset pulse in RUN, then a restart of the hold count
      rst_req = 1'b1; tick(); rst_req = 1'b0;
      check_eq("t4_core_reset_up", 32'(core_reset), 32'd1);
      measure_high(n);
      check_eq("t4_pulse_len", 32'(n), 32'(HOLD_CYC) + 32'd1);
      rst_req = 1'b1; tick(); rst_req = 1'b0;
      for (int i = 0; i < 5; i++) tick();
      rst_req = 1'b1; tick(); rst_req = 1'b0;
      check_eq("t4_restart_hold", 32'(dbg.hold_cnt), 32'(HOLD_CYC));
      measure_high(n);
      check_eq("t4_restart_len", 32'(n), 32'(HOLD_CYC) + 32'd1);

      // game mode and DIPs during RUN
      ioctl_download = 1'b1;
      wr_byte(IDX_MODE, 25'd0, 8'h03);
      check_eq("t5_game_mode", 32'(game_mode), 32'd3);
      check_eq("t5_core_reset", 32'(core_reset), 32'd0);
      wr_byte(IDX_DIP, 25'd0, 8'h12);
      wr_byte(IDX_DIP, 25'd1, 8'h34);
      wr_byte(IDX_DIP, 25'd2, 8'h56);
      check_eq("t5_sw0", 32'(sw0), 32'h12);
      check_eq("t5_sw1", 32'(sw1), 32'h34);
      end_dl();
      check_eq("t5_state_kept", 32'(dbg.state), 32'(ST_RUN));

      // reset in the middle of a download
      load_rom(100, 0);
      tick();
      reset = 1'b1; ioctl_download = 1'b0;
      tick();
      reset = 1'b0;
      check_eq("t6_state", 32'(dbg.state), 32'(ST_IDLE));
      check_eq("t6_core_reset", 32'(core_reset), 32'd1);
      check_eq("t6_load_busy", 32'(load_busy), 32'd0);
      check_eq("t6_cnt", 32'(dbg.byte_cnt), 32'd0);
      tick(); tick();
      check_eq("t6_stays_idle", 32'(dbg.state), 32'(ST_IDLE));
      check_eq("queue_drained", 32'(exp_q.size()), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
